// File: rtl/operand_regfile.sv
// Operand register file: NREG general registers with a selectable writeback
// source, registered A/B operand outputs with write-first forwarding, a
// registered status word and a wrapping writeback counter.
module operand_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       RA,
    input  logic [2:0]       RB,
    input  logic [2:0]       DA,
    input  logic             WE,
    input  logic [1:0]       MD,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] INK,
    input  logic [3:0]       NZCV,
    input  logic             FL,
    input  logic             STALL,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       ST,
    output logic [7:0]       WCNT
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       st_q, st_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // Writeback source select.
    always_comb begin
        wd = '0;
        unique case (MD)
            2'b00:   wd = F;
            2'b01:   wd = IN;
            2'b10:   wd = INK;
            default: wd = '0;
        endcase
    end

    // Register reads, write-first forwarding and next-state for all state.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (32'(RA) < NREG) rd_a = regs_q[RA];
        if (32'(RB) < NREG) rd_b = regs_q[RB];

        regs_d = regs_q;
        if (WE && (32'(DA) < NREG)) regs_d[DA] = wd;

        a_d = a_q;
        b_d = b_q;
        if (!STALL) begin
            // Forward A and B independently when the same register is being written.
            a_d = (WE && (RA == DA)) ? wd : rd_a;
            b_d = (WE && (RB == DA)) ? wd : rd_b;
        end

        st_d   = FL ? NZCV : st_q;
        wcnt_d = WE ? wcnt_q + 8'd1 : wcnt_q;
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
            a_q    <= '0;
            b_q    <= '0;
            st_q   <= '0;
            wcnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            a_q    <= a_d;
            b_q    <= b_d;
            st_q   <= st_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign ST   = st_q;
    assign WCNT = wcnt_q;

endmodule

// File: tb/tb_operand_regfile.sv
// Directed bench for operand_regfile.
module tb_operand_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] RA, RB, DA;
    logic       WE;
    logic [1:0] MD;
    logic [7:0] F, IN, INK;
    logic [3:0] NZCV;
    logic       FL, STALL;
    logic [7:0] A, B;
    logic [3:0] ST;
    logic [7:0] WCNT;

    int checks   = 0;
    int failures = 0;

    operand_regfile #(.WIDTH(8), .NREG(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .RA   (RA),
        .RB   (RB),
        .DA   (DA),
        .WE   (WE),
        .MD   (MD),
        .F    (F),
        .IN   (IN),
        .INK  (INK),
        .NZCV (NZCV),
        .FL   (FL),
        .STALL(STALL),
        .A    (A),
        .B    (B),
        .ST   (ST),
        .WCNT (WCNT)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        RA = 3'd0; RB = 3'd0; DA = 3'd0; WE = 1'b0; MD = 2'b00;
        F = 8'h00; IN = 8'h00; INK = 8'h00; NZCV = 4'h0; FL = 1'b0; STALL = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({A, B, ST, WCNT} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs got A=%h B=%h ST=%h WCNT=%h want all 0", A, B, ST, WCNT);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RA = 3'(i);
            RB = 3'(7 - i);
            step();
            checks++;
            if (A !== 8'h00 || B !== 8'h00 || ST !== 4'h0 || WCNT !== 8'h00) begin
                failures++;
                $display("FAIL reset_read_%0d got A=%h B=%h ST=%h WCNT=%h want 0", i, A, B, ST,
                         WCNT);
            end
        end
    endtask

    task automatic test_write_read();
        WE = 1'b1; DA = 3'd3; MD = 2'b01; IN = 8'h5A;
        RA = 3'd0;
        step();
        WE = 1'b0; RA = 3'd3;
        step();
        checks++;
        if (A !== 8'h5A) begin
            failures++;
            $display("FAIL write_read_A got %h want 5a", A);
        end
        checks++;
        if (WCNT !== 8'd1) begin
            failures++;
            $display("FAIL write_read_WCNT got %0d want 1", WCNT);
        end
    endtask

    task automatic test_forward();
        WE = 1'b1; DA = 3'd5; MD = 2'b00; F = 8'h11; RA = 3'd0; RB = 3'd0;
        step();
        WE = 1'b1; DA = 3'd5; MD = 2'b00; F = 8'hC3; RA = 3'd5; RB = 3'd5;
        step();
        checks++;
        if (A !== 8'hC3 || B !== 8'hC3) begin
            failures++;
            $display("FAIL forward_AB got A=%h B=%h want c3 c3", A, B);
        end
        WE = 1'b0; F = 8'h00; RA = 3'd5; RB = 3'd3;
        step();
        checks++;
        if (A !== 8'hC3 || B !== 8'h5A) begin
            failures++;
            $display("FAIL forward_stored got A=%h B=%h want c3 5a", A, B);
        end
        checks++;
        if (WCNT !== 8'd3) begin
            failures++;
            $display("FAIL forward_WCNT got %0d want 3", WCNT);
        end
    endtask

    task automatic test_stall();
        WE = 1'b1; MD = 2'b01; DA = 3'd1; IN = 8'h22;
        step();
        DA = 3'd2; IN = 8'h99;
        step();
        WE = 1'b0; RA = 3'd1;
        step();
        checks++;
        if (A !== 8'h22) begin
            failures++;
            $display("FAIL stall_preload got A=%h want 22", A);
        end
        STALL = 1'b1; RA = 3'd2;
        for (int i = 0; i < 3; i++) begin
            // Write R4 during the first stalled cycle.
            WE = (i == 0); DA = 3'd4; MD = 2'b10; INK = 8'h44;
            step();
            checks++;
            if (A !== 8'h22) begin
                failures++;
                $display("FAIL stall_hold_%0d got A=%h want 22", i, A);
            end
        end
        WE = 1'b0; STALL = 1'b0; RA = 3'd4; RB = 3'd2;
        step();
        checks++;
        if (A !== 8'h44 || B !== 8'h99) begin
            failures++;
            $display("FAIL stall_write got A=%h B=%h want 44 99", A, B);
        end
        checks++;
        if (WCNT !== 8'd6) begin
            failures++;
            $display("FAIL stall_WCNT got %0d want 6", WCNT);
        end
    endtask

    task automatic test_flags_sources();
        FL = 1'b1; NZCV = 4'b1010;
        step();
        checks++;
        if (ST !== 4'b1010) begin
            failures++;
            $display("FAIL flag_load got ST=%b want 1010", ST);
        end
        FL = 1'b0; NZCV = 4'b0101;
        step();
        step();
        checks++;
        if (ST !== 4'b1010) begin
            failures++;
            $display("FAIL flag_hold got ST=%b want 1010", ST);
        end
        WE = 1'b1; DA = 3'd6; MD = 2'b10; INK = 8'h7F; F = 8'h01; IN = 8'h02;
        step();
        WE = 1'b0; RA = 3'd6;
        step();
        checks++;
        if (A !== 8'h7F) begin
            failures++;
            $display("FAIL md_ink got A=%h want 7f", A);
        end
        WE = 1'b1; DA = 3'd6; MD = 2'b11; INK = 8'hFF; F = 8'hFF; IN = 8'hFF;
        step();
        WE = 1'b0; RA = 3'd6;
        step();
        checks++;
        if (A !== 8'h00) begin
            failures++;
            $display("FAIL md_zero got A=%h want 00", A);
        end
        checks++;
        if (WCNT !== 8'd8) begin
            failures++;
            $display("FAIL flags_WCNT got %0d want 8", WCNT);
        end
    endtask

    task automatic test_wrap_and_reset();
        idle_inputs();
        do_reset();
        FL = 1'b1; NZCV = 4'b1111;
        WE = 1'b1; MD = 2'b01;
        for (int i = 0; i < 256; i++) begin
            DA = 3'(i % 8);
            IN = 8'(i);
            step();
            if (i == 254) begin
                checks++;
                if (WCNT !== 8'hFF) begin
                    failures++;
                    $display("FAIL wcnt_ff got %h want ff", WCNT);
                end
            end
        end
        checks++;
        if (WCNT !== 8'h00) begin
            failures++;
            $display("FAIL wcnt_wrap got %h want 00", WCNT);
        end
        WE = 1'b0; FL = 1'b0; RA = 3'd0; RB = 3'd7;
        step();
        checks++;
        if (A !== 8'hF8 || B !== 8'hFF || ST !== 4'hF) begin
            failures++;
            $display("FAIL wrap_regs got A=%h B=%h ST=%h want f8 ff f", A, B, ST);
        end
        // Mid-cycle reset with a write and flag load pending.
        WE = 1'b1; DA = 3'd2; IN = 8'hAB; FL = 1'b1; NZCV = 4'b0110;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, ST, WCNT} !== 28'h0) begin
            failures++;
            $display("FAIL async_reset got A=%h B=%h ST=%h WCNT=%h want all 0", A, B, ST,
                     WCNT);
        end
        step();
        checks++;
        if ({A, B, ST, WCNT} !== 28'h0) begin
            failures++;
            $display("FAIL reset_edge got A=%h B=%h ST=%h WCNT=%h want all 0", A, B, ST, WCNT);
        end
        rst_n = 1'b1;
        WE = 1'b0; FL = 1'b0; RA = 3'd2; RB = 3'd7;
        step();
        checks++;
        if (A !== 8'h00 || B !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_regs got A=%h B=%h want 00 00", A, B);
        end
        WE = 1'b1; DA = 3'd0; MD = 2'b01; IN = 8'h3C; RA = 3'd0;
        step();
        checks++;
        if (A !== 8'h3C || WCNT !== 8'd1) begin
            failures++;
            $display("FAIL resume got A=%h WCNT=%0d want 3c 1", A, WCNT);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1;
        test_reset();
        test_write_read();
        test_forward();
        test_stall();
        test_flags_sources();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_regfile.md
OPERAND_REGFILE -- requirements
Module: operand_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, datapath width in bits.
REQ-002 The block SHALL have parameter NREG, default 8, number of general registers; address width is 3 bits.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port RA  input  3  register address for operand A.
REQ-006 The block SHALL have port RB  input  3  register address for operand B.
REQ-007 The block SHALL have port DA  input  3  destination register address for writeback.
REQ-008 The block SHALL have port WE  input  1  writeback enable.
REQ-009 The block SHALL have port MD  input  2  writeback source select: 00 = F, 01 = IN, 10 = INK, 11 = zero.
REQ-010 The block SHALL have port F  input  WIDTH  ALU result.
REQ-011 The block SHALL have port IN  input  WIDTH  external input data.
REQ-012 The block SHALL have port INK  input  WIDTH  immediate constant.
REQ-013 The block SHALL have port NZCV  input  4  ALU flags {N,Z,C,V}.
REQ-014 The block SHALL have port FL  input  1  status flag load enable.
REQ-015 The block SHALL have port STALL  input  1  operand-register hold.
REQ-016 The block SHALL have port A  output  WIDTH  registered operand A to the ALU.
REQ-017 The block SHALL have port B  output  WIDTH  registered operand B to the ALU.
REQ-018 The block SHALL have port ST  output  4  registered status {N,Z,C,V}.
REQ-019 The block SHALL have port WCNT  output  8  count of completed writebacks, wrapping.

Function
REQ-020 The block SHALL select writeback data WD combinationally from MD per REQ-009.
REQ-021 The block SHALL write WD into register DA on a rising edge when WE=1, regardless of STALL.
REQ-022 The block SHALL leave all registers unchanged when WE=0.
REQ-023 The block SHALL load A from register RA and B from register RB on each rising edge when STALL=0, for a read latency of one cycle.
REQ-024 The block SHALL hold A and B unchanged when STALL=1.
REQ-025 The block SHALL forward write data (write-first): when WE=1, STALL=0 and RA==DA in the same cycle, A SHALL load WD, not the old register contents; likewise for B when RB==DA.
REQ-026 The block SHALL apply forwarding to A and B independently, so RA==RB==DA gives A=B=WD.
REQ-027 The block SHALL have no combinational path from F, IN, INK or NZCV to A, B or ST.
REQ-028 The block SHALL load ST from NZCV on a rising edge when FL=1 and hold ST otherwise; FL is independent of WE and STALL.
REQ-029 The block SHALL increment WCNT by 1 on each edge with WE=1, wrapping from 0xFF to 0x00.
REQ-030 The block SHALL treat all registers, including register 0, as writable general registers.

Reset
REQ-031 The block SHALL, while rst_n=0, immediately force all NREG registers, A, B, ST and WCNT to zero, independent of clk.
REQ-032 The block SHALL ignore any write, flag load or operand load presented on the edge coinciding with rst_n=0.
REQ-033 The block SHALL resume normal operation on the first rising edge after rst_n returns to 1.

Verification
REQ-034 The bench SHALL check: reset, then RA=0..7 and RB=7..0 over 8 cycles -> A=B=0x00 every cycle, ST=0, WCNT=0.
REQ-035 The bench SHALL check: WE=1, DA=3, MD=01, IN=0x5A, then next cycle RA=3 -> A=0x5A one cycle later, WCNT=1.
REQ-036 The bench SHALL check: R5=0x11, then in one cycle WE=1, DA=5, MD=00, F=0xC3, RA=RB=5 -> A=B=0xC3 after the edge.
REQ-037 The bench SHALL check: A=0x22, then STALL=1 with RA pointing at 0x99 for 3 cycles -> A stays 0x22; a WE during the stall still updates the register.
REQ-038 The bench SHALL check: FL=1, NZCV=1010, then FL=0, NZCV=0101 -> ST=1010 held; MD=10, INK=0x7F writes 0x7F; MD=11 writes 0x00.
REQ-039 The bench SHALL check: 256 writebacks -> WCNT returns to 0x00; then rst_n pulsed low mid-cycle after writes -> all outputs 0 before the next edge.
